branch_update_controller: RTL

BRANCH_UPDATE_CONTROLLER -- requirements
Module: branch_update_controller

---
 rtl/branch_update_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_update_controller.sv
// In-order branch record queue with predictor update/rollback sequencing.
// Optional perf counters: define BRANCH_UPDATE_PERF_COUNTERS_EN.
module branch_update_controller #(
  parameter int unsigned HISTORY_LEN = 10,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     predict_valid,
  input  logic [15:0]              predict_pc,
  input  logic [HISTORY_LEN-1:0]   predict_history,
  input  logic                     predict_taken,
  output logic                     predict_ready,
  output logic                     predict_enable,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     write_enabled,
  output logic                     outcome,
  output logic [15:0]              pc_bits_write,
  output logic [HISTORY_LEN-1:0]   history_write,
  output logic                     rollback_enabled,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
`ifdef BRANCH_UPDATE_PERF_COUNTERS_EN
  output logic [15:0]              perf_resolved,
  output logic [15:0]              perf_mispredicted,
`endif
  output logic                     err_underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StRollback} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [15:0]       pc_mem    [DEPTH];
  logic [HISTORY_LEN-1:0] hist_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;
  logic              accept, mismatch, underflow;

  always_comb begin
    predict_ready  = (count_q != Full) && (state_q == StIdle);
    predict_enable = predict_valid && predict_ready;
    resolve_ready  = (state_q == StIdle);
    accept         = resolve_valid && resolve_ready && (count_q != '0);
    mismatch       = accept && (resolve_taken != taken_mem[head_q]);
    underflow      = resolve_valid && resolve_ready && (count_q == '0);
    state_d        = state_q;
    if (mismatch) begin
      state_d = StRollback;
    end else if (state_q == StRollback) begin
      state_d = StIdle;
    end
  end

  assign count = count_q;

  // Record storage is not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (predict_enable) begin
      pc_mem[tail_q]    <= predict_pc;
      hist_mem[tail_q]  <= predict_history;
      taken_mem[tail_q] <= predict_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= StIdle;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      err_underflow    <= 1'b0;
      write_enabled    <= 1'b0;
      outcome          <= 1'b0;
      rollback_enabled <= 1'b0;
      flush            <= 1'b0;
      pc_bits_write    <= '0;
      history_write    <= '0;
    end else begin
      state_q          <= state_d;
      write_enabled    <= 1'b0;
      rollback_enabled <= 1'b0;
      flush            <= 1'b0;
      if (underflow) err_underflow <= 1'b1;
      if (accept) begin
        write_enabled <= 1'b1;
        outcome       <= resolve_taken;
        pc_bits_write <= pc_mem[head_q];
        history_write <= hist_mem[head_q];
      end
      // The write pulse left head pc/history and the real outcome in the
      // output registers; the restore history is that history shifted by it.
      if (state_q == StRollback) begin
        rollback_enabled <= 1'b1;
        flush            <= 1'b1;
        history_write    <= {history_write[HISTORY_LEN-2:0], outcome};
      end
      if (mismatch) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (predict_enable) tail_q <= tail_q + 1'b1;
        if (accept) head_q <= head_q + 1'b1;
        case ({predict_enable, accept})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef BRANCH_UPDATE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_resolved     <= '0;
      perf_mispredicted <= '0;
    end else begin
      if (accept && (perf_resolved != 16'hFFFF)) perf_resolved <= perf_resolved + 16'd1;
      if (mismatch && (perf_mispredicted != 16'hFFFF)) begin
        perf_mispredicted <= perf_mispredicted + 16'd1;
      end
    end
  end
`endif

endmodule
